core_dma: RTL and testbench
===========================

CORE_DMA -- requirements
Module: core_dma

Interface
REQ-001 Parameter: TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer.
REQ-002 Parameter: TARGET_ADDR, 16'h2004, fixed destination address for every DMA write.
REQ-003 Port: I_clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: I_reset  in  1  asynchronous, active-high reset.
REQ-005 Port: I_cycle_end  in  1  one-I_clock strobe marking the end of each CPU bus cycle; not gated by ready.
REQ-006 Port: I_core_addr  in  16  core address for the current cycle.
REQ-007 Port: I_core_wr_data  in  8  core write data.
REQ-008 Port: I_core_rdwr  in  1  core direction; 1=read, 0=write.
REQ-009 Port: O_core_ready  out  1  ready to core; 0 freezes the core.
REQ-010 Port: I_rd_data  in  8  memory read data, sampled at I_cycle_end.
REQ-011 Port: O_addr  out  16  address to memory.
REQ-012 Port: O_wr_data  out  8  write data to memory.
REQ-013 Port: O_rdwr  out  1  direction to memory; 1=read.
REQ-014 Port: O_busy  out  1  high whenever state is not IDLE.

Function
REQ-015 All state SHALL advance only on I_clock edges where I_cycle_end=1.
REQ-016 The parity bit SHALL toggle at every I_cycle_end; "even cycle" means parity=0 during that cycle.
REQ-017 States SHALL be IDLE, HALT, ALIGN, READ and WRITE.
REQ-018 IDLE: on I_cycle_end with I_core_rdwr=0 and I_core_addr=TRIGGER_ADDR, the block SHALL latch page=I_core_wr_data, clear index, and go to HALT.
REQ-019 HALT SHALL last one cycle, then go to READ if the next cycle is even, else to ALIGN.
REQ-020 ALIGN SHALL last one cycle, then go to READ.
REQ-021 READ: O_addr={page,index}, O_rdwr=1; at I_cycle_end, data_reg<=I_rd_data; then go to WRITE.
REQ-022 WRITE: O_addr=TARGET_ADDR, O_wr_data=data_reg, O_rdwr=0; at I_cycle_end, index+=1 (8-bit).
REQ-023 WRITE exit: if index was 8'hFF, go to IDLE; otherwise go to READ.
REQ-024 The transfer SHALL therefore be exactly 256 READ/WRITE pairs, and index wrap to 0 SHALL end the transfer.
REQ-025 O_core_ready SHALL be 1 only in IDLE; it is combinational from state.
REQ-026 In IDLE, O_addr/O_wr_data/O_rdwr SHALL pass the core signals through unchanged.
REQ-027 In HALT and ALIGN, O_addr=I_core_addr and O_rdwr=1 (dummy read), so that no core write repeats while it is frozen.
REQ-028 Total stall SHALL be 513 cycles if the trigger cycle is even, or 514 cycles if it is odd.
REQ-029 Trigger writes while O_busy=1 SHALL be ignored.
REQ-030 Any write to an address other than TRIGGER_ADDR SHALL have no effect.

Reset
REQ-031 While I_reset=1: state=IDLE, parity=0, index=0, page=0, data_reg=0.
REQ-032 Consequently O_core_ready=1 and O_busy=0, and the bus outputs equal the core pass-through.
REQ-033 Reset asserted mid-transfer SHALL abort immediately with no further DMA bus cycles.
REQ-034 After reset release, the first cycle SHALL be even.

Structure
REQ-035 Package core_dma_signals SHALL hold the state enum typedef and the DMA_TRIGGER_ADDR/DMA_TARGET_ADDR constants used as parameter defaults.
REQ-036 The design is a single flat module, with no sub-module.
REQ-037 Registers: state (3b), parity, page (8b), index (8b), data_reg (8b).

Verification
REQ-038 Reset, then core write 8'h02 to 16'h4014 on cycle 0 (even) -> O_core_ready low for exactly 513 cycles; first READ at 16'h0200, last WRITE at 16'h2004 with mem[16'h02FF].
REQ-039 Same trigger on an odd cycle -> one ALIGN cycle; stall is 514 cycles; READs occur only on even cycles.
REQ-040 Memory page 8'h07 filled with i^8'h5A, trigger with 8'h07 -> 256 writes to 16'h2004 carrying 8'h5A, 8'h5B, ... in order.
REQ-041 Assert I_reset at READ of index 8'h40 -> next edge: O_busy=0, O_core_ready=1, pass-through; no further write to 16'h2004.
REQ-042 Hold I_cycle_end low for 10 clocks mid-transfer -> no state, index or output change.
REQ-043 Core write to 16'h4015 or read of 16'h4014 -> O_busy stays 0.

Source files
------------

// File: rtl/core_dma_signals.sv
// Shared types and default addresses for the core DMA engine.
package core_dma_signals;

  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] DMA_TARGET_ADDR  = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/core_dma.sv
// Page-copy DMA: freezes the core, then streams 256 bytes of one page
// to a fixed target address as alternating read/write bus cycles.
module core_dma
  import core_dma_signals::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = DMA_TRIGGER_ADDR,
  parameter logic [15:0] TARGET_ADDR  = DMA_TARGET_ADDR
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_cycle_end,
  input  logic [15:0] I_core_addr,
  input  logic [7:0]  I_core_wr_data,
  input  logic        I_core_rdwr,
  output logic        O_core_ready,
  input  logic [7:0]  I_rd_data,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_busy
);

  dma_state_t  r_state;
  logic        r_parity;
  logic [7:0]  r_page;
  logic [7:0]  r_index;
  logic [7:0]  r_data;

  dma_state_t  w_state_next;
  logic [7:0]  w_page_next;
  logic [7:0]  w_index_next;
  logic [7:0]  w_data_next;
  logic        w_trigger;

  assign w_trigger = (I_core_addr == TRIGGER_ADDR) && !I_core_rdwr;

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      r_state  <= ST_IDLE;
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_index  <= 8'h00;
      r_data   <= 8'h00;
    end else if (I_cycle_end) begin
      r_state  <= w_state_next;
      r_parity <= ~r_parity;
      r_page   <= w_page_next;
      r_index  <= w_index_next;
      r_data   <= w_data_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_page_next  = r_page;
    w_index_next = r_index;
    w_data_next  = r_data;
    O_addr       = I_core_addr;
    O_wr_data    = I_core_wr_data;
    O_rdwr       = I_core_rdwr;

    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_state_next = ST_HALT;
          w_page_next  = I_core_wr_data;
          w_index_next = 8'h00;
        end
      end
      ST_HALT: begin
        // Frozen core cycle is turned into a dummy read so its write never lands twice.
        O_rdwr       = 1'b1;
        w_state_next = r_parity ? ST_READ : ST_ALIGN;
      end
      ST_ALIGN: begin
        O_rdwr       = 1'b1;
        w_state_next = ST_READ;
      end
      ST_READ: begin
        O_addr       = {r_page, r_index};
        O_rdwr       = 1'b1;
        w_data_next  = I_rd_data;
        w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        O_addr       = TARGET_ADDR;
        O_wr_data    = r_data;
        O_rdwr       = 1'b0;
        w_index_next = r_index + 8'h01;
        w_state_next = (r_index == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign O_core_ready = (r_state == ST_IDLE);
  assign O_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_core_dma.sv
// Directed bench for core_dma: scoreboard of expected bus cycles per transfer.
module tb_core_dma;

  localparam logic [15:0] TRIG       = 16'h4014;
  localparam logic [15:0] TGT        = 16'h2004;
  localparam logic [15:0] STALL_ADDR = 16'h1234;

  logic        I_clock = 1'b0;
  logic        I_reset = 1'b1;
  logic        I_cycle_end = 1'b0;
  logic [15:0] I_core_addr = 16'h0000;
  logic [7:0]  I_core_wr_data = 8'h00;
  logic        I_core_rdwr = 1'b1;
  logic [7:0]  I_rd_data;
  logic        O_core_ready;
  logic [15:0] O_addr;
  logic [7:0]  O_wr_data;
  logic        O_rdwr;
  logic        O_busy;

  core_dma #(
    .TRIGGER_ADDR(TRIG),
    .TARGET_ADDR (TGT)
  ) dut (
    .I_clock       (I_clock),
    .I_reset       (I_reset),
    .I_cycle_end   (I_cycle_end),
    .I_core_addr   (I_core_addr),
    .I_core_wr_data(I_core_wr_data),
    .I_core_rdwr   (I_core_rdwr),
    .O_core_ready  (O_core_ready),
    .I_rd_data     (I_rd_data),
    .O_addr        (O_addr),
    .O_wr_data     (O_wr_data),
    .O_rdwr        (O_rdwr),
    .O_busy        (O_busy)
  );

  always #5 I_clock = ~I_clock;

  logic [7:0] mem [0:65535];
  assign I_rd_data = mem[O_addr];

  typedef struct {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  data;
    int          kind;  // 0 halt/align, 1 read, 2 write
  } txn_t;

  txn_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cycle_num = 0;
  int stall_cnt = 0;

  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic        s_rdwr, s_ready, s_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycle_num);
    end
  endtask

  task automatic core_set(input logic [15:0] a, input logic [7:0] d, input logic rw);
    I_core_addr    = a;
    I_core_wr_data = d;
    I_core_rdwr    = rw;
  endtask

  // One bus cycle: a quiet clock, then a clock carrying the cycle_end strobe.
  task automatic do_cycle();
    I_cycle_end = 1'b0;
    @(posedge I_clock); #1;
    I_cycle_end = 1'b1;
    s_addr  = O_addr;
    s_wdata = O_wr_data;
    s_rdwr  = O_rdwr;
    s_ready = O_core_ready;
    s_busy  = O_busy;
    @(posedge I_clock); #1;
    I_cycle_end = 1'b0;
    cycle_num++;
  endtask

  task automatic make_even();
    if (cycle_num % 2 != 0) begin
      core_set(16'h0100, 8'h00, 1'b1);
      do_cycle();
      check("idle_busy", s_busy, 1'b0);
    end
  endtask

  task automatic trigger(input logic [7:0] page);
    txn_t e;
    int t;
    t = cycle_num;
    core_set(TRIG, page, 1'b0);
    e.addr = STALL_ADDR; e.rdwr = 1'b1; e.data = 8'h00; e.kind = 0;
    exp_q.push_back(e);
    if (t % 2 != 0) exp_q.push_back(e);
    for (int i = 0; i < 256; i++) begin
      e.addr = {page, i[7:0]}; e.rdwr = 1'b1; e.data = 8'h00; e.kind = 1;
      exp_q.push_back(e);
      e.addr = TGT; e.rdwr = 1'b0; e.data = mem[{page, i[7:0]}]; e.kind = 2;
      exp_q.push_back(e);
    end
    do_cycle();
    check("trig_ready", s_ready, 1'b1);
    check("trig_pass_addr", s_addr, TRIG);
    check("trig_pass_rdwr", s_rdwr, 1'b0);
    check("trig_pass_data", s_wdata, page);
    core_set(STALL_ADDR, 8'hEE, 1'b1);
    stall_cnt = 0;
  endtask

  task automatic run_n(input int n);
    txn_t e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      do_cycle();
      e = exp_q.pop_front();
      if (!s_ready) stall_cnt++;
      check("stall_ready", s_ready, 1'b0);
      check("stall_busy", s_busy, 1'b1);
      check("bus_addr", s_addr, e.addr);
      check("bus_rdwr", s_rdwr, e.rdwr);
      if (e.kind == 2) check("wr_data", s_wdata, e.data);
      if (e.kind == 1) check("read_even", (cycle_num - 1) % 2, 0);
    end
  endtask

  task automatic finish_transfer(input int exp_stall);
    run_n(exp_q.size());
    do_cycle();
    check("end_ready", s_ready, 1'b1);
    check("end_busy", s_busy, 1'b0);
    check("end_pass_addr", s_addr, STALL_ADDR);
    check("stall_len", stall_cnt, exp_stall);
  endtask

  initial begin
    int wr_seen;
    for (int i = 0; i < 256; i++) begin
      mem[{8'h02, i[7:0]}] = 8'($urandom_range(0, 255));
      mem[{8'h05, i[7:0]}] = 8'($urandom_range(0, 255));
      mem[{8'h07, i[7:0]}] = i[7:0] ^ 8'h5A;
      mem[{8'h03, i[7:0]}] = ~i[7:0];
    end

    // Reset state with core pass-through
    core_set(16'h1111, 8'h22, 1'b0);
    repeat (3) @(posedge I_clock);
    #1;
    check("rst_ready", O_core_ready, 1'b1);
    check("rst_busy", O_busy, 1'b0);
    check("rst_addr", O_addr, 16'h1111);
    check("rst_wdata", O_wr_data, 8'h22);
    check("rst_rdwr", O_rdwr, 1'b0);
    I_reset = 1'b0;
    cycle_num = 0;

    // Near-miss triggers
    core_set(16'h4015, 8'h02, 1'b0);
    do_cycle();
    check("miss_4015_busy", O_busy, 1'b0);
    core_set(TRIG, 8'h02, 1'b1);
    do_cycle();
    check("miss_rd4014_busy", O_busy, 1'b0);
    check("miss_rd4014_rdwr", s_rdwr, 1'b1);

    // Even trigger: 513-cycle stall
    make_even();
    trigger(8'h02);
    finish_transfer(513);

    // Odd trigger: ALIGN inserted, 514-cycle stall
    if (cycle_num % 2 == 0) begin
      core_set(16'h0100, 8'h00, 1'b1);
      do_cycle();
    end
    trigger(8'h05);
    finish_transfer(514);

    // Pattern page, cycle_end hold, and trigger write while busy
    make_even();
    trigger(8'h07);
    run_n(101);
    for (int k = 0; k < 10; k++) begin
      @(posedge I_clock); #1;
      check("hold_addr", O_addr, exp_q[0].addr);
      check("hold_rdwr", O_rdwr, exp_q[0].rdwr);
      check("hold_busy", O_busy, 1'b1);
    end
    core_set(TRIG, 8'h01, 1'b0);
    run_n(100);
    core_set(STALL_ADDR, 8'hEE, 1'b1);
    finish_transfer(513);

    // Reset during READ of index 0x40
    make_even();
    trigger(8'h03);
    run_n(129);
    check("pre_rst_addr", O_addr, 16'h0340);
    check("pre_rst_rdwr", O_rdwr, 1'b1);
    I_reset = 1'b1;
    @(posedge I_clock); #1;
    check("abort_busy", O_busy, 1'b0);
    check("abort_ready", O_core_ready, 1'b1);
    check("abort_addr", O_addr, STALL_ADDR);
    check("abort_rdwr", O_rdwr, 1'b1);
    check("abort_wdata", O_wr_data, 8'hEE);
    I_reset = 1'b0;
    exp_q.delete();
    cycle_num = 0;
    wr_seen = 0;
    repeat (300) begin
      do_cycle();
      if (!s_rdwr && s_addr == TGT) wr_seen++;
    end
    check("no_dma_after_rst", wr_seen, 0);
    check("post_rst_busy", s_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
